// File: rtl/cordic_sequencer_pkg.sv
// cordic_sequencer_pkg: shared defaults, FSM states, mode encodings and gain constant for the CORDIC sequencer
//   FIXED_WIDTH / ITERATIONS / GUARD : default datapath geometry
//   state_t                          : sequencer FSM states
//   MODE_ROT / MODE_VEC              : mode input encodings
//   GAIN_COMP                        : 1/K pre-scale for unit-magnitude rotation (2.14)
package cordic_sequencer_pkg;
    localparam int FIXED_WIDTH = 16;
    localparam int ITERATIONS  = 9;
    localparam int GUARD       = 2;
    localparam logic [15:0] GAIN_COMP = 16'h26DD;
    localparam logic MODE_ROT = 1'b0;
    localparam logic MODE_VEC = 1'b1;
    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;
endpackage

// File: rtl/cordic_microrot.sv
// cordic_microrot: one combinational CORDIC shift-add micro-rotation
//   x_i, y_i, z_i : working values before the step
//   i_i           : iteration index (shift amount)
//   angle_i       : atan(2^-i) from the angle ROM
//   mode_i        : MODE_ROT drives z to 0, MODE_VEC drives y to 0
//   x_o, y_o, z_o : working values after the step
module cordic_microrot
    import cordic_sequencer_pkg::*;
#(
    parameter int FW = FIXED_WIDTH,
    parameter int XW = FIXED_WIDTH + GUARD,
    parameter int IW = $clog2(ITERATIONS)
) (
    input  logic signed [XW-1:0] x_i,
    input  logic signed [XW-1:0] y_i,
    input  logic signed [FW-1:0] z_i,
    input  logic        [IW-1:0] i_i,
    input  logic signed [FW-1:0] angle_i,
    input  logic                 mode_i,
    output logic signed [XW-1:0] x_o,
    output logic signed [XW-1:0] y_o,
    output logic signed [FW-1:0] z_o
);
    logic pos;
    logic signed [XW-1:0] xs, ys;
    always_comb begin
        // pos means sigma = +1
        pos = (mode_i == MODE_VEC) ? y_i[XW-1] : ~z_i[FW-1];
        xs  = x_i >>> i_i;
        ys  = y_i >>> i_i;
        x_o = pos ? x_i - ys : x_i + ys;
        y_o = pos ? y_i + xs : y_i - xs;
        z_o = pos ? z_i - angle_i : z_i + angle_i;
    end
endmodule

// File: rtl/cordic_sequencer.sv
// cordic_sequencer: iterative CORDIC controller, one micro-rotation per clock
//   clk, rst_n            : clock, asynchronous active-low reset
//   start, mode           : launch request (ignored while busy), 0=rotation 1=vectoring
//   x_in, y_in, z_in      : signed 2.14 operands, sampled with start
//   angle_idx, angle_in   : external arctangent ROM index and its combinational data
//   busy, done            : iterating / one-cycle result-valid pulse
//   x_out, y_out, z_out   : results (x/y saturated), held until the next result
module cordic_sequencer
    import cordic_sequencer_pkg::*;
#(
    parameter int FIXED_WIDTH = cordic_sequencer_pkg::FIXED_WIDTH,
    parameter int ITERATIONS  = cordic_sequencer_pkg::ITERATIONS,
    parameter int GUARD       = cordic_sequencer_pkg::GUARD
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic                           mode,
    input  logic signed [FIXED_WIDTH-1:0]  x_in,
    input  logic signed [FIXED_WIDTH-1:0]  y_in,
    input  logic signed [FIXED_WIDTH-1:0]  z_in,
    output logic [$clog2(ITERATIONS)-1:0]  angle_idx,
    input  logic signed [FIXED_WIDTH-1:0]  angle_in,
    output logic                           busy,
    output logic                           done,
    output logic signed [FIXED_WIDTH-1:0]  x_out,
    output logic signed [FIXED_WIDTH-1:0]  y_out,
    output logic signed [FIXED_WIDTH-1:0]  z_out
);
    localparam int FW = FIXED_WIDTH;
    localparam int XW = FIXED_WIDTH + GUARD;
    localparam int IW = $clog2(ITERATIONS);
    localparam logic [IW-1:0] LAST = IW'(ITERATIONS - 1);

    state_t state_q, state_d;
    logic [IW-1:0] i_q, i_d;
    logic signed [XW-1:0] x_q, x_d, y_q, y_d, x_nx, y_nx;
    logic signed [FW-1:0] z_q, z_d, z_nx, xo_q, xo_d, yo_q, yo_d, zo_q, zo_d;
    logic mode_q, mode_d;

    // In range iff the guard bits and the result sign bit all agree
    function automatic logic signed [FW-1:0] sat(input logic signed [XW-1:0] v);
        logic [GUARD:0] top;
        top = v[XW-1:FW-1];
        return (&top || ~|top) ? v[FW-1:0] : {v[XW-1], {(FW-1){~v[XW-1]}}};
    endfunction

    cordic_microrot #(.FW(FW), .XW(XW), .IW(IW)) u_rot (
        .x_i(x_q), .y_i(y_q), .z_i(z_q), .i_i(i_q), .angle_i(angle_in), .mode_i(mode_q),
        .x_o(x_nx), .y_o(y_nx), .z_o(z_nx)
    );

    always_comb begin
        state_d = ST_IDLE;
        i_d     = i_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        mode_d  = mode_q;
        xo_d    = xo_q;
        yo_d    = yo_q;
        zo_d    = zo_q;
        if (state_q == ST_RUN) begin
            state_d = (i_q == LAST) ? ST_DONE : ST_RUN;
            i_d     = i_q + 1'b1;
            x_d     = x_nx;
            y_d     = y_nx;
            z_d     = z_nx;
            if (i_q == LAST) begin
                xo_d = sat(x_nx);
                yo_d = sat(y_nx);
                zo_d = z_nx;
            end
        end else if (start) begin
            state_d = ST_RUN;
            i_d     = '0;
            x_d     = {{GUARD{x_in[FW-1]}}, x_in};
            y_d     = {{GUARD{y_in[FW-1]}}, y_in};
            z_d     = z_in;
            mode_d  = mode;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            i_q     <= '0;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            mode_q  <= MODE_ROT;
            xo_q    <= '0;
            yo_q    <= '0;
            zo_q    <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            mode_q  <= mode_d;
            xo_q    <= xo_d;
            yo_q    <= yo_d;
            zo_q    <= zo_d;
        end
    end

    assign busy      = (state_q == ST_RUN);
    assign done      = (state_q == ST_DONE);
    assign angle_idx = busy ? i_q : '0;
    assign x_out     = xo_q;
    assign y_out     = yo_q;
    assign z_out     = zo_q;
endmodule

// File: tb/tb_cordic_sequencer.sv
// tb_cordic_sequencer: directed and random checks of cordic_sequencer against an arithmetic CORDIC model
module tb_cordic_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic mode = 1'b0;
    logic signed [15:0] x_in = '0, y_in = '0, z_in = '0, angle_in;
    logic [3:0] angle_idx;
    logic busy, done;
    logic signed [15:0] x_out, y_out, z_out;

    int total = 0;
    int bad = 0;
    int rom [9] = '{12868, 7596, 4014, 2037, 1023, 512, 256, 128, 64};
    int idx_q[$];

    always #5 clk = ~clk;

    assign angle_in = (angle_idx < 9) ? 16'(rom[angle_idx]) : 16'sd0;

    cordic_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
        .x_in(x_in), .y_in(y_in), .z_in(z_in),
        .angle_idx(angle_idx), .angle_in(angle_in),
        .busy(busy), .done(done),
        .x_out(x_out), .y_out(y_out), .z_out(z_out)
    );

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic chk_near(input string tag, input int got, input int exp, input int tol);
        total++;
        assert (got >= exp - tol && got <= exp + tol) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d+-%0d", tag, got, exp, tol);
        end
    endtask

    function automatic int clamp16(input int v);
        return (v > 32767) ? 32767 : (v < -32768) ? -32768 : v;
    endfunction

    // Plain-integer CORDIC: sigma from the current residual, z kept as a wrapping 16-bit value
    function automatic void model(input bit m, input int x0, input int y0, input int z0,
                                  output int xo, output int yo, output int zo);
        int x, y, z, nx, ny;
        x = x0; y = y0; z = z0;
        for (int k = 0; k < 9; k++) begin
            int s;
            s  = (m ? (y < 0) : (z >= 0)) ? 1 : -1;
            nx = x - s * (y >>> k);
            ny = y + s * (x >>> k);
            z  = int'(shortint'(z - s * rom[k]));
            x  = nx;
            y  = ny;
        end
        xo = clamp16(x);
        yo = clamp16(y);
        zo = z;
    endfunction

    task automatic launch(input bit m, input int x, input int y, input int z);
        @(negedge clk);
        mode = m; x_in = 16'(x); y_in = 16'(y); z_in = 16'(z); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called one negedge after the accepting edge; returns edges from start to done
    task automatic wait_done(input bit poke, output int lat);
        lat = 1;
        idx_q.delete();
        while (!done && lat < 40) begin
            if (busy) idx_q.push_back(int'(angle_idx));
            if (poke && (lat == 3 || lat == 7)) begin
                start = 1'b1; mode = ~mode;
                x_in = 16'($urandom); y_in = 16'($urandom); z_in = 16'($urandom);
            end else start = 1'b0;
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        if (!done) begin
            total++; bad++;
            $error("FAIL timeout observed=no_done expected=done");
        end
    endtask

    task automatic check_op(input string tag, input bit m, input int x, input int y, input int z, input int lat);
        int ex, ey, ez;
        model(m, x, y, z, ex, ey, ez);
        chk({tag, "_lat"}, lat, 10);
        chk({tag, "_busy_in_done"}, int'(busy), 0);
        chk({tag, "_x"}, int'(x_out), ex);
        chk({tag, "_y"}, int'(y_out), ey);
        chk({tag, "_z"}, int'(z_out), ez);
    endtask

    initial begin
        int lat, seq_err, rx, ry, rz;
        bit rm;
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_idx", int'(angle_idx), 0);
        chk("rst_x", int'(x_out), 0);
        chk("rst_z", int'(z_out), 0);
        @(negedge clk);
        rst_n = 1'b1;

        launch(0, 9949, 0, 0);
        wait_done(0, lat);
        check_op("rot0", 0, 9949, 0, 0, lat);
        chk_near("rot0_x_spec", int'(x_out), 16384, 80);
        chk_near("rot0_y_spec", int'(y_out), 0, 80);
        seq_err = 0;
        foreach (idx_q[k]) if (idx_q[k] != k) seq_err++;
        chk("idx_count", idx_q.size(), 9);
        chk("idx_order_errs", seq_err, 0);
        @(negedge clk);
        chk("done_pulse_one_cycle", int'(done), 0);
        chk("idle_idx", int'(angle_idx), 0);

        launch(0, 9949, 0, 12868);
        wait_done(0, lat);
        check_op("rot45", 0, 9949, 0, 12868, lat);
        chk_near("rot45_x_spec", int'(x_out), 11585, 80);
        chk_near("rot45_y_spec", int'(y_out), 11585, 80);
        chk_near("rot45_z_spec", int'(z_out), 0, 80);

        launch(1, 8192, 8192, 0);
        wait_done(0, lat);
        check_op("vec", 1, 8192, 8192, 0, lat);
        chk_near("vec_z_spec", int'(z_out), 12868, 80);
        chk_near("vec_x_spec", int'(x_out), 19079, 80);
        chk_near("vec_y_spec", int'(y_out), 0, 80);

        // Reset mid-run: outputs from the previous op must clear asynchronously
        launch(0, 9949, 0, 12868);
        repeat (3) @(negedge clk);
        chk("pre_rst_busy", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_done", int'(done), 0);
        chk("midrst_idx", int'(angle_idx), 0);
        chk("midrst_x", int'(x_out), 0);
        chk("midrst_y", int'(y_out), 0);
        chk("midrst_z", int'(z_out), 0);
        @(negedge clk);
        rst_n = 1'b1;
        launch(1, 16384, 16384, 0);
        wait_done(0, lat);
        check_op("vecsat", 1, 16384, 16384, 0, lat);
        chk("vecsat_x_spec", int'(x_out), 32767);
        chk_near("vecsat_z_spec", int'(z_out), 12868, 80);

        // Starts at run cycles 3 and 7 must be ignored
        launch(0, 5000, -3000, 7000);
        wait_done(1, lat);
        check_op("poked", 0, 5000, -3000, 7000, lat);

        // Start in the DONE cycle launches immediately
        mode = 1'b1; x_in = 16'sd12000; y_in = -16'sd4000; z_in = 16'sd100; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("b2b_busy", int'(busy), 1);
        wait_done(0, lat);
        check_op("b2b", 1, 12000, -4000, 100, lat);

        for (int n = 0; n < 20; n++) begin
            rm = 1'($urandom);
            rx = int'(shortint'($urandom));
            ry = int'(shortint'($urandom));
            rz = int'(shortint'($urandom));
            launch(rm, rx, ry, rz);
            wait_done(0, lat);
            check_op("rand", rm, rx, ry, rz, lat);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
